// File: rtl/fetch_unit_g7_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit_g7_if
//  Purpose  : Bundles the instruction-memory request/response channel and the
//             decode-side instruction channel of the fetch unit.
//  Ports    : master - the fetch unit (drives imem_req/imem_addr and the if_*
//                      outputs, receives grant/response/ready/redirect)
//             slave  - the environment (memory + decode + branch unit)
//  Revision : 1.0 - initial release
// ============================================================================
interface fetch_unit_g7_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [6:0]  if_opcode;
    logic        if_illegal;
    logic        if_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output if_valid, if_instr, if_pc, if_opcode, if_illegal,
        input  if_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  if_valid, if_instr, if_pc, if_opcode, if_illegal,
        output if_ready, redirect, redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit_g7.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit_g7
//  Purpose  : Instruction fetch front end. Issues word-aligned fetch requests
//             under a credit rule that bounds in-flight plus buffered words
//             to DEPTH, buffers returned words with their PC in a FIFO and
//             presents the head entry to decode. A redirect flushes the FIFO
//             and marks every in-flight response for discard.
//  Ports    : clk   - clock, rising edge
//             rst_n - asynchronous active-low reset
//             bus   - fetch_unit_g7_if.master (imem_* request/response,
//                     if_* decode channel, redirect/redirect_pc)
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_unit_g7 #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    fetch_unit_g7_if.master     bus
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_CW:0] c_DEPTH = DEPTH[c_CW:0];

    localparam logic [6:0] c_OP_R    = 7'b0110011;
    localparam logic [6:0] c_OP_ADDI = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD = 7'b0000011;
    localparam logic [6:0] c_OP_S    = 7'b0100011;
    localparam logic [6:0] c_OP_B    = 7'b1100011;

    logic [31:0]     r_fetch_pc;
    logic [31:0]     r_ret_pc;
    logic [c_CW-1:0] r_outst;
    logic [c_CW-1:0] r_discard;
    logic [c_CW-1:0] r_count;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW-1:0] r_wr_ptr;
    logic [31:0]     r_buf_pc    [DEPTH];
    logic [31:0]     r_buf_instr [DEPTH];

    logic            w_valid;
    logic            w_pop;
    logic [c_CW:0]   w_credit_used;
    logic            w_req;
    logic            w_gnt;
    logic            w_keep;
    logic [c_CW-1:0] w_outst_next;
    logic [31:0]     w_redir_pc;
    logic [31:0]     w_head_instr;
    logic [6:0]      w_head_op;
    logic            w_unused_ok;

    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid & bus.if_ready;

    // Credits: words in flight plus words buffered, less the one leaving this
    // cycle, must leave room for one more; this is what keeps the FIFO from
    // ever overflowing. Gated by rst_n so no request escapes during reset.
    assign w_credit_used = {1'b0, r_outst} + {1'b0, r_count} - {{c_CW{1'b0}}, w_pop};
    assign w_req         = rst_n & ~bus.redirect & (w_credit_used < c_DEPTH);
    assign w_gnt         = w_req & bus.imem_gnt;

    // A response is kept only when nothing is pending discard and no redirect
    // is flushing the path in this same cycle.
    assign w_keep       = bus.imem_rvalid & (r_discard == '0) & ~bus.redirect;
    assign w_outst_next = r_outst + c_CW'(w_gnt) - c_CW'(bus.imem_rvalid);
    assign w_redir_pc   = {bus.redirect_pc[31:2], 2'b00};
    assign w_unused_ok  = &{1'b0, bus.redirect_pc[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_ret_pc   <= RESET_PC;
            r_outst    <= '0;
            r_discard  <= '0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            r_outst <= w_outst_next;
            if (bus.redirect) begin
                // Every word still owed by memory after this edge belongs to
                // the old path; earlier pending discards are already included.
                r_discard  <= w_outst_next;
                r_fetch_pc <= w_redir_pc;
                r_ret_pc   <= w_redir_pc;
                r_count    <= '0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
            end else begin
                if (bus.imem_rvalid && (r_discard != '0)) begin
                    r_discard <= r_discard - c_CW'(1);
                end
                if (w_gnt) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_keep) begin
                    r_ret_pc <= r_ret_pc + 32'd4;
                    r_wr_ptr <= r_wr_ptr + c_AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_AW'(1);
                end
                r_count <= r_count + c_CW'(w_keep) - c_CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_keep) begin
            r_buf_pc[r_wr_ptr]    <= r_ret_pc;
            r_buf_instr[r_wr_ptr] <= bus.imem_rdata;
        end
    end

    // Head outputs are forced to zero when empty so reset and flushed states
    // present clean values to decode.
    assign w_head_instr = w_valid ? r_buf_instr[r_rd_ptr] : 32'h0;
    assign w_head_op    = w_head_instr[6:0];

    assign bus.imem_req   = w_req;
    assign bus.imem_addr  = r_fetch_pc;
    assign bus.if_valid   = w_valid;
    assign bus.if_instr   = w_head_instr;
    assign bus.if_pc      = w_valid ? r_buf_pc[r_rd_ptr] : 32'h0;
    assign bus.if_opcode  = w_head_op;
    assign bus.if_illegal = w_valid & ~((w_head_op == c_OP_R)    |
                                        (w_head_op == c_OP_ADDI) |
                                        (w_head_op == c_OP_LOAD) |
                                        (w_head_op == c_OP_S)    |
                                        (w_head_op == c_OP_B));

endmodule
`default_nettype wire
